// File: rtl/noc_pkg.sv
// Shared mesh definitions: default flit/key widths and where the key sits within a flit.
package noc_pkg;

    localparam int NOC_DATA_W   = 8;
    localparam int NOC_KEY_W    = 8;
    localparam int FLIT_KEY_LSB = 0;

    typedef logic [NOC_DATA_W-1:0] flit_t;

endpackage

// File: rtl/dup_filter_cam.sv
// Key history for dup_filter: DEPTH-entry FIFO-replaced key store with parallel match.
module dup_cam
    import noc_pkg::*;
#(
    parameter int KEY_W = NOC_KEY_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [KEY_W-1:0] key_i,
    output logic             hit_o,
    input  logic             wr_en_i,
    input  logic [KEY_W-1:0] wr_key_i,
    input  logic             flush_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [KEY_W-1:0] key_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;

    // Match uses only the registered table, so a key written this edge is visible next cycle.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (key_q[i] == key_i)) begin
                hit_o = 1'b1;
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            vld_d    = '0;
            wr_ptr_d = '0;
        end else if (wr_en_i) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !flush_i) begin
            key_q[wr_ptr_q] <= wr_key_i;
        end
    end

endmodule

// File: rtl/dup_filter.sv
// Duplicate-suppression stage in front of a node input port: drops flits whose key was
// recently seen and forwards new ones through a 1-deep registered ready/valid pipe.
module dup_filter
    import noc_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W,
    parameter int KEY_W  = NOC_KEY_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              vld_q;
    logic              vld_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;
    logic [KEY_W-1:0]  key;
    logic              hit;
    logic              accept;
    logic              miss;
    logic              drop;

    assign key     = i_data[FLIT_KEY_LSB +: KEY_W];
    assign o_ready = !vld_q || i_ready;
    assign accept  = i_valid && o_ready;
    // A flush in the accept cycle overrides any hit: the flit is forwarded, not recorded.
    assign miss    = accept && (!hit || i_flush);
    assign drop    = accept && hit && !i_flush;

    dup_cam #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH)
    ) u_cam (
        .clk      (clk),
        .rstn     (rstn),
        .key_i    (key),
        .hit_o    (hit),
        .wr_en_i  (miss),
        .wr_key_i (key),
        .flush_i  (i_flush)
    );

    always_comb begin
        vld_d      = vld_q;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        if (miss) begin
            vld_d  = 1'b1;
            data_d = i_data;
        end else if (i_ready) begin
            vld_d  = 1'b0;
        end
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q      <= 1'b0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            vld_q      <= vld_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_valid    = vld_q;
    assign o_data     = data_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dup_filter.sv
// Directed bench for dup_filter: forwarding, duplicate drop, wrap eviction, backpressure,
// flush race and asynchronous reset.
module tb_dup_filter;

    logic        clk;
    logic        rstn;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        i_ready;
    logic        i_flush;
    logic [15:0] o_drop_cnt;

    int vectors;
    int miscompares;

    dup_filter dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .i_flush    (i_flush),
        .o_drop_cnt (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one flit for exactly one clock edge; returns 1 time unit after the edge.
    task automatic send(input logic [7:0] d);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b1;
        i_valid     = 1'b0;
        i_data      = 8'h00;
        i_ready     = 1'b1;
        i_flush     = 1'b0;
        #2;

        // Reset state
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_cnt", o_drop_cnt, 0);
        chk("rst_ready", o_ready, 1);
        rstn = 1'b1;

        // Plain forwarding
        send(8'h11);
        chk("fwd11_valid", o_valid, 1);
        chk("fwd11_data", o_data, 8'h11);
        send(8'h22);
        chk("fwd22_data", o_data, 8'h22);
        send(8'h33);
        chk("fwd33_data", o_data, 8'h33);
        @(posedge clk);
        #1;
        chk("fwd_idle_valid", o_valid, 0);
        chk("fwd_cnt", o_drop_cnt, 0);

        // Back-to-back duplicate
        do_reset();
        send(8'h11);
        chk("b2b_first_data", o_data, 8'h11);
        chk("b2b_ready", o_ready, 1);
        send(8'h11);
        chk("b2b_second_valid", o_valid, 0);
        chk("b2b_cnt", o_drop_cnt, 1);
        chk("b2b_ready_after", o_ready, 1);

        // Wrap eviction: 0x08 overwrites 0x00, then 0x00 overwrites 0x01
        do_reset();
        for (int k = 0; k < 9; k++) send(8'(k));
        chk("wrap_last_data", o_data, 8'h08);
        send(8'h00);
        chk("wrap_readd_valid", o_valid, 1);
        chk("wrap_readd_data", o_data, 8'h00);
        send(8'h02);
        chk("wrap_hit_valid", o_valid, 0);
        chk("wrap_hit_cnt", o_drop_cnt, 1);
        send(8'h01);
        chk("wrap_evicted_valid", o_valid, 1);
        chk("wrap_evicted_data", o_data, 8'h01);
        chk("wrap_evicted_cnt", o_drop_cnt, 1);

        // Backpressure
        do_reset();
        i_ready = 1'b0;
        send(8'hA1);
        chk("bp_first_data", o_data, 8'hA1);
        chk("bp_ready_low", o_ready, 0);
        i_valid = 1'b1;
        i_data  = 8'hA2;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", o_data, 8'hA1);
            chk("bp_hold_valid", o_valid, 1);
            chk("bp_hold_ready", o_ready, 0);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_release_ready", o_ready, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("bp_drain_data", o_data, 8'hA2);
        chk("bp_drain_valid", o_valid, 1);
        @(posedge clk);
        #1;
        chk("bp_empty_valid", o_valid, 0);
        chk("bp_cnt", o_drop_cnt, 0);

        // Flush race: 0x44 recorded, then flushed in the same cycle it is re-sent
        send(8'h44);
        chk("fl_pre_data", o_data, 8'h44);
        i_flush = 1'b1;
        send(8'h44);
        i_flush = 1'b0;
        chk("fl_race_valid", o_valid, 1);
        chk("fl_race_data", o_data, 8'h44);
        chk("fl_race_cnt", o_drop_cnt, 0);
        send(8'h44);
        chk("fl_second_valid", o_valid, 1);
        chk("fl_second_cnt", o_drop_cnt, 0);
        send(8'h44);
        chk("fl_third_valid", o_valid, 0);
        chk("fl_third_cnt", o_drop_cnt, 1);
        send(8'hA1);
        chk("fl_cleared_valid", o_valid, 1);
        chk("fl_cleared_data", o_data, 8'hA1);

        // Asynchronous reset while a flit is held
        i_ready = 1'b0;
        send(8'h55);
        chk("ar_held_valid", o_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_async_valid", o_valid, 0);
        chk("ar_async_data", o_data, 0);
        chk("ar_async_cnt", o_drop_cnt, 0);
        #1;
        rstn    = 1'b1;
        i_ready = 1'b1;
        send(8'h44);
        chk("ar_after_valid", o_valid, 1);
        chk("ar_after_data", o_data, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
